pipe_muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer that owns the HI/LO register pair for the static pipeline CPU. It accepts MULT/MULTU/DIV/DIVU from the EX stage and runs a 32-step shift-add or restoring-divide engine. It holds the pipeline via `stall` while any instruction touches HI/LO before the result is ready. MTHI/MTLO writes and MFHI/MFLO reads are serviced from the registers it holds, and the MEM stage consumes `hi`/`lo` directly.

---
 rtl/pipe_muldiv_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_pipe_muldiv_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_muldiv_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair; stalls the pipe while HI/LO are pending.
// Optional build macro PIPE_MULDIV_FAST_MUL_EN: single-cycle multiplies, divides stay iterative.
module pipe_muldiv_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            rd_hilo,
  input  logic            wr_hi,
  input  logic            wr_lo,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  // state | meaning
  // IDLE  | HI/LO readable/writable, waiting for start
  // RUN   | one multiply/divide step per cycle, steps 0..31
  // FIX   | sign correction, HI/LO write, done pulse
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [4:0] LAST_STEP = 5'(XLEN - 1);

  state_t state, state_nxt;
  logic   accept;

  logic [4:0]      step;
  logic [XLEN-1:0] opd;
  logic [XLEN-1:0] acc_hi;
  logic [XLEN-1:0] acc_lo;
  logic [XLEN-1:0] a_save;
  logic            is_div;
  logic            neg_res;
  logic            neg_rem;
  logic            div0;

  logic            signed_op;
  logic            neg_a, neg_b;
  logic [XLEN-1:0] mag_a, mag_b;

  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_sh;
  logic              div_ge;
  logic [XLEN-1:0]   div_sub;
  logic [2*XLEN-1:0] mul_p, mul_res;
  logic [XLEN-1:0]   quo, rem;

  logic              fast_hit;
  logic [2*XLEN-1:0] fast_p;

  assign signed_op = ~op[0];
  assign neg_a     = signed_op & a[XLEN-1];
  assign neg_b     = signed_op & b[XLEN-1];
  assign mag_a     = neg_a ? -a : a;
  assign mag_b     = neg_b ? -b : b;

`ifdef PIPE_MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_mag;
  assign fast_mag = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
  assign fast_p   = (neg_a ^ neg_b) ? -fast_mag : fast_mag;
  assign fast_hit = accept & ~op[1];
`else
  assign fast_p   = '0;
  assign fast_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept = 1'b1;
`ifdef PIPE_MULDIV_FAST_MUL_EN
          if (op[1]) state_nxt = S_RUN;
`else
          state_nxt = S_RUN;
`endif
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (step == LAST_STEP) state_nxt = S_FIX;
      end
      S_FIX: begin
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign stall = busy & (start | rd_hilo | wr_hi | wr_lo);

  // acc_hi holds the running remainder, which stays below the divisor, so 32 bits suffice.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opd} : '0);
  assign div_sh  = {acc_hi, acc_lo[XLEN-1]};
  assign div_ge  = div_sh >= {1'b0, opd};
  assign div_sub = div_sh[XLEN-1:0] - opd;

  assign mul_p   = {acc_hi, acc_lo};
  assign mul_res = neg_res ? -mul_p : mul_p;
  assign quo     = neg_res ? -acc_lo : acc_lo;
  assign rem     = neg_rem ? -acc_hi : acc_hi;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      step    <= '0;
      opd     <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      a_save  <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      div0    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (fast_hit) begin
            hi   <= fast_p[2*XLEN-1:XLEN];
            lo   <= fast_p[XLEN-1:0];
            done <= 1'b1;
          end else if (accept) begin
            step    <= '0;
            opd     <= mag_b;
            acc_hi  <= '0;
            acc_lo  <= mag_a;
            a_save  <= a;
            is_div  <= op[1];
            neg_res <= neg_a ^ neg_b;
            neg_rem <= neg_a;
            div0    <= (b == '0);
          end else begin
            // a start in the same cycle overwrites HI/LO anyway, so writes only land here
            if (wr_hi) hi <= wdata;
            if (wr_lo) lo <= wdata;
          end
        end
        S_RUN: begin
          step <= step + 5'd1;
          if (is_div) begin
            if (div_ge) begin
              acc_hi <= div_sub;
              acc_lo <= {acc_lo[XLEN-2:0], 1'b1};
            end else begin
              acc_hi <= div_sh[XLEN-1:0];
              acc_lo <= {acc_lo[XLEN-2:0], 1'b0};
            end
          end else begin
            acc_hi <= mul_sum[XLEN:1];
            acc_lo <= {mul_sum[0], acc_lo[XLEN-1:1]};
          end
        end
        S_FIX: begin
          done <= 1'b1;
          if (!is_div) begin
            hi <= mul_res[2*XLEN-1:XLEN];
            lo <= mul_res[XLEN-1:0];
          end else if (div0) begin
            hi <= a_save;
            lo <= '1;
          end else begin
            hi <= rem;
            lo <= quo;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_muldiv_ctrl.sv
// Self-checking bench for pipe_muldiv_ctrl: directed cases plus random ops against an arithmetic model.
module tb_pipe_muldiv_ctrl;

`ifdef PIPE_MULDIV_FAST_MUL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a, b;
  logic        rd_hilo, wr_hi, wr_lo;
  logic [31:0] wdata;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_muldiv_ctrl #(.XLEN(32)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .rd_hilo (rd_hilo),
    .wr_hi   (wr_hi),
    .wr_lo   (wr_lo),
    .wdata   (wdata),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish (got timeout, need completion)");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference results straight from the instruction definitions.
  function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, sq, sr;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    eh = '0;
    el = '0;
    case (o)
      2'd0: begin p = 64'(sx * sy); eh = p[63:32]; el = p[31:0]; end
      2'd1: begin p = {32'b0, x} * {32'b0, y}; eh = p[63:32]; el = p[31:0]; end
      2'd2: begin
        if (y == 32'd0) begin eh = x; el = 32'hFFFF_FFFF; end
        else begin
          sq = sx / sy;
          sr = sx % sy;
          el = 32'(sq);
          eh = 32'(sr);
        end
      end
      default: begin
        if (y == 32'd0) begin eh = x; el = 32'hFFFF_FFFF; end
        else begin el = x / y; eh = x % y; end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input logic wl);
    logic [31:0] eh, el;
    int lat;
    bit fast;
    model(o, x, y, eh, el);
    fast = FAST && !o[1];
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1; wr_lo = wl; wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0; a = $urandom; b = $urandom;
    chk("busy_after_accept", 64'(busy), 64'(fast ? 1'b0 : 1'b1));
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    chk("latency", 64'(lat), 64'(fast ? 1 : 34));
    chk("hi", 64'(hi), 64'(eh));
    chk("lo", 64'(lo), 64'(el));
    chk("busy_at_done", 64'(busy), 64'd0);
    @(negedge clk);
    chk("done_single_pulse", 64'(done), 64'd0);
  endtask

  initial begin
    logic [31:0] eh, el;
    logic [1:0]  ro;
    logic [31:0] ra, rb;
    logic [1:0]  sop;
    int stall_cnt;
    int done_seen;
    bit released;

    rstn = 1'b0; start = 1'b0; op = 2'd0; a = '0; b = '0;
    rd_hilo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rstn = 1'b1;

    // MTHI + MTLO together, then MTHI alone
    @(negedge clk);
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'hA5A5_A5A5;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    chk("mt_both_hi", 64'(hi), 64'hA5A5_A5A5);
    chk("mt_both_lo", 64'(lo), 64'hA5A5_A5A5);
    wr_hi = 1'b1; wdata = 32'h0000_0011;
    #1 chk("idle_no_stall", 64'(stall), 64'd0);
    @(negedge clk);
    wr_hi = 1'b0;
    chk("mthi_hi", 64'(hi), 64'h11);
    chk("mthi_lo_kept", 64'(lo), 64'hA5A5_A5A5);

    // Directed cases; the first also drives MTLO alongside start.
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b1);
    chk("mult_neg3x5_hi", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_neg3x5_lo", 64'(lo), 64'hFFFF_FFF1);
    run_op(2'd3, 32'd100, 32'd7, 1'b0);
    chk("divu_100_7_lo", 64'(lo), 64'd14);
    chk("divu_100_7_hi", 64'(hi), 64'd2);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_m7_2_lo", 64'(lo), 64'hFFFF_FFFD);
    chk("div_m7_2_hi", 64'(hi), 64'hFFFF_FFFF);
    run_op(2'd2, 32'h0000_1234, 32'd0, 1'b0);
    chk("div0_lo", 64'(lo), 64'hFFFF_FFFF);
    chk("div0_hi", 64'(hi), 64'h1234);
    run_op(2'd3, 32'h8000_0001, 32'd0, 1'b0);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("div_wrap_lo", 64'(lo), 64'h8000_0000);
    chk("div_wrap_hi", 64'(hi), 64'd0);
    run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 1'b0);
    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 1'b0);

    // Read-after-op interlock; uses an iterative op so the stall window exists in every build.
    sop = FAST ? 2'd3 : 2'd1;
    model(sop, 32'd123456789, 32'd987654321, eh, el);
    @(negedge clk);
    op = sop; a = 32'd123456789; b = 32'd987654321; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rd_hilo = 1'b1;
    start = 1'b1;
    #1 chk("stall_start_busy", 64'(stall), 64'd1);
    start = 1'b0;
    stall_cnt = 0;
    released = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (!busy) begin
        released = 1'b1;
        break;
      end
      if (stall) stall_cnt++;
      @(negedge clk);
    end
    chk("stall_released", 64'(released), 64'd1);
    chk("stall_cycles", 64'(stall_cnt), 64'd32);
    chk("rd_first_idle_stall", 64'(stall), 64'd0);
    chk("rd_first_idle_hi", 64'(hi), 64'(eh));
    chk("rd_first_idle_lo", 64'(lo), 64'(el));
    @(negedge clk);
    rd_hilo = 1'b0;

    // Reset in the middle of a DIVU
    @(negedge clk);
    op = 2'd3; a = 32'd100; b = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    rstn = 1'b0;
    #1;
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    chk("midrst_no_done", 64'(done_seen), 64'd0);
    chk("midrst_hi_kept", 64'(hi), 64'd0);
    run_op(2'd3, 32'd100, 32'd7, 1'b0);

    // Random ops, occasionally with a zero divisor.
    for (int i = 0; i < 30; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 20));
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
